// File: rtl/mux4_arbiter_if.sv
// Handshake bundle between the four requesting pipeline units and the
// mux4_arbiter. The arbiter side uses the slave modport; the requesters
// (or a testbench standing in for them) use the master modport.
interface mux4_arbiter_if;
    logic [3:0] req;    // level request per requester
    logic [3:0] done;   // release pulse, meaningful only for the owner
    logic [3:0] gnt;    // one-hot registered grant
    logic [1:0] sel;    // binary index of the owner, drives the shared mux
    logic       busy;   // any grant active

    modport master (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy
    );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for one shared 4:1 datapath mux.
// Grants are registered and one-hot, and are held until the owner drops its
// request or pulses done. Hand-off to the next requester happens on the
// same edge as the release, so there is no idle cycle between owners.
// Optional feature: define MUX4_ARB_TIMEOUT_EN to force a hand-off once an
// owner has held the mux for MAX_HOLD cycles while another requester waits.
module mux4_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    mux4_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Reject hold limits outside the supported range at elaboration time.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("mux4_arbiter: MAX_HOLD must be within 2..255");
    end

    state_t     state_q, state_d;
    logic [1:0] last_q,  last_d;    // most recent winner; also the owner in OWN
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;

    logic [3:0] owner_mask;
    logic       release_now;
    logic       new_grant;
    logic       timeout;
    logic [2:0] pick;               // {found, index}

    // First candidate in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                           input logic [1:0] ptr);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (cand[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    assign owner_mask = 4'b0001 << last_q;

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam int HC_W = $clog2(MAX_HOLD) + 1;

    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    // Preempt only when the limit is reached and someone else is waiting.
    assign timeout = (hold_cnt_q == HC_W'(MAX_HOLD)) &&
                     (|(bus.req & ~owner_mask));

    // Hold counter: restart at 1 on each new grant, count owned cycles, saturate.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant) begin
            hold_cnt_d = HC_W'(1);
        end else if (state_q == OWN && hold_cnt_q != HC_W'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state, grant and select selection for the IDLE/OWN machine.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        new_grant   = 1'b0;
        pick        = 3'b000;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, last_q);
            end
            OWN: begin
                // A simultaneous req drop and done is still a single release.
                release_now = !bus.req[last_q] || bus.done[last_q] || timeout;
                if (release_now) begin
                    // The released owner is excluded for this edge only.
                    pick = rr_pick(bus.req & ~owner_mask, last_q);
                    if (!pick[2]) begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        if (pick[2]) begin
            new_grant = 1'b1;
            state_d   = OWN;
            last_d    = pick[1:0];
            sel_d     = pick[1:0];
            gnt_d     = 4'b0001 << pick[1:0];
        end
    end

    // Arbiter state register; reset points last at 3 so requester 0 leads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = |gnt_q;

endmodule
